// File: rtl/stopwatch_if.sv
// Signal bundle between the tick/button front end and the MM:SS stopwatch core.
// master = stimulus/front-end side, slave = stopwatch_core side.
interface stopwatch_if;
  // No valid/ready here: ticks and pause_pulse are single-cycle enables qualified by clk,
  // adj/sel are levels, and every output is a registered value that is always valid.
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_pulse;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       paused;
  logic [1:0] adj_field;
  logic [1:0] state_dbg;

  modport master (
    output tick_1hz, tick_2hz, pause_pulse, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, paused, adj_field, state_dbg
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_pulse, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, paused, adj_field, state_dbg
  );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with pause and per-field adjust, clocked by clk_100mhz with tick enables.
// Optional macro STOPWATCH_WRAP_EN: wrap to 00:00 at MIN_LIMIT:SEC_LIMIT instead of saturating.
module stopwatch_core #(
  parameter int MIN_LIMIT = 59,
  parameter int SEC_LIMIT = 59
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  stopwatch_if.slave sw
);

  localparam logic [7:0] MIN_LIM_BCD = 8'(((MIN_LIMIT / 10) * 16) + (MIN_LIMIT % 10));
  localparam logic [7:0] SEC_LIM_BCD = 8'(((SEC_LIMIT / 10) * 16) + (SEC_LIMIT % 10));

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_ADJ_MIN = 2'd2,
    ST_ADJ_SEC = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       paused_q, paused_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [1:0] adj_field;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
    end
  end

  // Ticks act on the current (registered) state and old paused value; adj and
  // pause_pulse only steer where the state goes next.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    min_d    = min_q;
    sec_d    = sec_q;

    if (sw.pause_pulse) paused_d = ~paused_q;

    if (sw.adj)          state_d = sw.sel ? ST_ADJ_SEC : ST_ADJ_MIN;
    else if (paused_d)   state_d = ST_HOLD;
    else                 state_d = ST_RUN;

    case (state_q)
      ST_RUN: begin
        if (!sw.adj && sw.tick_1hz) begin
          if (sec_q != SEC_LIM_BCD) begin
            sec_d = bcd_inc(sec_q);
          end else if (min_q != MIN_LIM_BCD) begin
            sec_d = 8'h00;
            min_d = bcd_inc(min_q);
          end else begin
`ifdef STOPWATCH_WRAP_EN
            sec_d = 8'h00;
            min_d = 8'h00;
`else
            sec_d = sec_q;
            min_d = min_q;
`endif
          end
        end
      end
      ST_ADJ_MIN: begin
        if (sw.adj && sw.tick_2hz) min_d = (min_q == MIN_LIM_BCD) ? 8'h00 : bcd_inc(min_q);
      end
      ST_ADJ_SEC: begin
        if (sw.adj && sw.tick_2hz) sec_d = (sec_q == SEC_LIM_BCD) ? 8'h00 : bcd_inc(sec_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    adj_field = 2'b00;
    case (state_q)
      ST_ADJ_MIN: adj_field = 2'b10;
      ST_ADJ_SEC: adj_field = 2'b01;
      default:    adj_field = 2'b00;
    endcase
  end

  assign sw.min_tens  = min_q[7:4];
  assign sw.min_ones  = min_q[3:0];
  assign sw.sec_tens  = sec_q[7:4];
  assign sw.sec_ones  = sec_q[3:0];
  assign sw.paused    = paused_q;
  assign sw.adj_field = adj_field;
  assign sw.state_dbg = state_q;

endmodule
